// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: read ports, write-back, issue and status.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 3
) ();
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     init_done;

  modport master (
    output rd_addr, wb_en, wb_addr, wb_data, issue_en, issue_addr,
    input  rd_data, rd_busy, init_done
  );

  modport slave (
    input  rd_addr, wb_en, wb_addr, wb_data, issue_en, issue_addr,
    output rd_data, rd_busy, init_done
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with a per-register busy scoreboard.
// After reset the file walks through every register writing its initial
// value (INIT), then accepts write-backs and issues (RUN). Reads are
// combinational with write-through bypass of the current write-back.
module regfile_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int NUM_RD    = 3,
  parameter int INIT_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   cnt_r;
  logic [ADDR_W-1:0]   cnt_nxt_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [DEPTH-1:0]    busy_r;
  logic [DEPTH-1:0]    busy_nxt_s;
  logic                init_done_r;

  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [DATA_W-1:0]   init_val_s;
  logic                run_s;

  logic [NUM_RD*DATA_W-1:0] rd_data_s;
  logic [NUM_RD-1:0]        rd_busy_s;

  assign run_s      = (state_r == ST_RUN);
  assign init_val_s = (INIT_MODE == 1) ? DATA_W'(cnt_r) : '0;

  // FSM next state: walk INIT until the last register is written, then stay in RUN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == LAST_IDX) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // Write port, init counter and scoreboard next values; issue is applied last so it wins.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = cnt_r;
    mem_wdata_s = init_val_s;
    cnt_nxt_s   = cnt_r;
    busy_nxt_s  = busy_r;
    case (state_r)
      ST_INIT: begin
        mem_we_s = 1'b1;
        if (cnt_r != LAST_IDX) begin
          cnt_nxt_s = cnt_r + ADDR_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_RUN: begin
        if (bus.wb_en) begin
          mem_we_s                = 1'b1;
          mem_waddr_s             = bus.wb_addr;
          mem_wdata_s             = bus.wb_data;
          busy_nxt_s[bus.wb_addr] = 1'b0;
        end else begin
          mem_we_s = 1'b0;
        end
        if (bus.issue_en) begin
          busy_nxt_s[bus.issue_addr] = 1'b1;
        end else begin
          busy_nxt_s[bus.issue_addr] = busy_nxt_s[bus.issue_addr];
        end
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Control state: FSM, init counter, scoreboard and init_done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_INIT;
      cnt_r       <= '0;
      busy_r      <= '0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      busy_r      <= busy_nxt_s;
      init_done_r <= (state_nxt_s == ST_RUN);
    end
  end

  // Register storage; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Combinational read ports with write-back bypass; contents hidden until RUN.
  always_comb begin
    rd_data_s = '0;
    rd_busy_s = '1;
    for (int k = 0; k < NUM_RD; k++) begin
      if (!run_s) begin
        rd_data_s[k*DATA_W +: DATA_W] = '0;
        rd_busy_s[k]                  = 1'b1;
      end else if (bus.wb_en && (bus.rd_addr[k*ADDR_W +: ADDR_W] == bus.wb_addr)) begin
        rd_data_s[k*DATA_W +: DATA_W] = bus.wb_data;
        rd_busy_s[k]                  = 1'b0;
      end else begin
        rd_data_s[k*DATA_W +: DATA_W] = mem_r[bus.rd_addr[k*ADDR_W +: ADDR_W]];
        rd_busy_s[k]                  = busy_r[bus.rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign bus.rd_data   = rd_data_s;
  assign bus.rd_busy   = rd_busy_s;
  assign bus.init_done = init_done_r;

endmodule
